// File: rtl/or1200_keccak_ctrl.sv
// l.cust5 sequencer between the OR1200 EX stage and a Keccak core: lane packing,
// core handshake, stall generation and digest readback. Optional KECCAK_CTRL_ERR_EN.
module or1200_keccak_ctrl #(
  parameter int unsigned OUT_W  = 512,
  parameter int unsigned LANE_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cust5_valid,
  input  logic [4:0]        cust5_op,
  input  logic [5:0]        cust5_limm,
  input  logic [31:0]       cust5_a,
  output logic              stall,
  output logic [31:0]       result,
  output logic              result_valid,
  output logic              kc_init,
  output logic [LANE_W-1:0] kc_in,
  output logic              kc_in_valid,
  output logic              kc_is_last,
  output logic [2:0]        kc_byte_num,
  input  logic              kc_buf_full,
  input  logic [OUT_W-1:0]  kc_out,
  input  logic              kc_out_ready,
  output logic              err
);

  localparam logic [4:0] OpInit   = 5'b00000;
  localparam logic [4:0] OpStart  = 5'b00100;
  localparam logic [4:0] OpMiddle = 5'b00010;
  localparam logic [4:0] OpEnd    = 5'b00001;
  localparam logic [4:0] OpStore  = 5'b01000;

  typedef enum logic [2:0] {
    StIdle,
    StAbsorb,
    StPush,
    StPushLast,
    StWaitOut,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic              accept;
  logic              act_init, act_start, act_middle, act_end, act_store;
  logic              seq_ok;
  logic              half_eff;
  logic [31:0]       half_q;
  logic              half_full_q;
  logic [LANE_W-1:0] lane_q;
  logic [2:0]        byte_num_q;
  logic [31:0]       result_q;
  logic              result_valid_q;
  logic              kc_init_q;
  logic [8:0]        word_bit;
  logic              unused_limm;

  assign unused_limm = ^cust5_limm[5:4];
  assign word_bit    = {cust5_limm[3:0], 5'd0};

  // A held upper word only counts while absorbing; an implicit start sees it empty.
  assign half_eff = half_full_q & (state_q == StAbsorb);

`ifdef KECCAK_CTRL_ERR_EN
  logic act_err;
  assign seq_ok = (state_q == StAbsorb);
`else
  assign seq_ok = (state_q inside {StAbsorb, StIdle, StDone});
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    act_init   = 1'b0;
    act_start  = 1'b0;
    act_middle = 1'b0;
    act_end    = 1'b0;
    act_store  = 1'b0;
`ifdef KECCAK_CTRL_ERR_EN
    act_err    = 1'b0;
`endif
    case (state_q)
      StPush:     if (!kc_buf_full) state_d = StAbsorb;
      StPushLast: if (!kc_buf_full) state_d = StWaitOut;
      StWaitOut:  if (kc_out_ready) state_d = StDone;
      default: ;
    endcase
    if (cust5_valid) begin
      case (cust5_op)
        OpInit: begin
          accept   = 1'b1;
          act_init = 1'b1;
          state_d  = StIdle;
        end
        OpStart: begin
          if (state_q inside {StIdle, StDone}) begin
            accept    = 1'b1;
            act_start = 1'b1;
            state_d   = StAbsorb;
          end else if (state_q == StAbsorb) begin
            accept = 1'b1;
`ifdef KECCAK_CTRL_ERR_EN
            act_err = 1'b1;
`else
            act_start = 1'b1;
`endif
          end
        end
        OpMiddle, OpEnd: begin
          if (seq_ok) begin
            accept = 1'b1;
            if (cust5_op == OpEnd) begin
              act_end = 1'b1;
              state_d = StPushLast;
            end else begin
              act_middle = 1'b1;
              state_d    = half_eff ? StPush : StAbsorb;
            end
          end
`ifdef KECCAK_CTRL_ERR_EN
          else if (state_q inside {StIdle, StDone, StWaitOut}) begin
            accept  = 1'b1;
            act_err = 1'b1;
          end
`endif
        end
        OpStore: begin
          if (state_q == StDone) begin
            accept    = 1'b1;
            act_store = 1'b1;
          end
        end
        default: accept = 1'b1;
      endcase
    end
  end

  always_comb begin
    kc_in_valid = (state_q == StPush) || (state_q == StPushLast);
    kc_is_last  = (state_q == StPushLast);
    stall       = cust5_valid & ~accept & ~rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q         <= '0;
      half_full_q    <= 1'b0;
      lane_q         <= '0;
      byte_num_q     <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      kc_init_q      <= 1'b0;
    end else begin
      kc_init_q      <= act_init;
      result_valid_q <= act_store;
      if (act_store) begin
        result_q <= kc_out[word_bit +: 32];
      end
      if (act_init) begin
        half_full_q <= 1'b0;
      end else if (act_start) begin
        half_q      <= cust5_a;
        half_full_q <= 1'b1;
      end else if (act_middle) begin
        if (half_eff) begin
          lane_q      <= {half_q, cust5_a};
          half_full_q <= 1'b0;
        end else begin
          half_q      <= cust5_a;
          half_full_q <= 1'b1;
        end
      end else if (act_end) begin
        lane_q      <= half_eff ? {half_q, cust5_a} : {cust5_a, 32'h0};
        half_full_q <= 1'b0;
        byte_num_q  <= cust5_limm[2:0];
      end
    end
  end

`ifdef KECCAK_CTRL_ERR_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (act_init) begin
      err_q <= 1'b0;
    end else if (act_err) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign kc_in        = lane_q;
  assign kc_byte_num  = byte_num_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign kc_init      = kc_init_q;

endmodule

// File: tb/tb_or1200_keccak_ctrl.sv
// Bench for or1200_keccak_ctrl: directed scenarios plus randomized messages checked
// against a word-pairing model of the lane stream and a digest word array.
module tb_or1200_keccak_ctrl;

  localparam logic [4:0] OpInit   = 5'b00000;
  localparam logic [4:0] OpStart  = 5'b00100;
  localparam logic [4:0] OpMiddle = 5'b00010;
  localparam logic [4:0] OpEnd    = 5'b00001;
  localparam logic [4:0] OpStore  = 5'b01000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cust5_valid;
  logic [4:0]   cust5_op;
  logic [5:0]   cust5_limm;
  logic [31:0]  cust5_a;
  logic         stall;
  logic [31:0]  result;
  logic         result_valid;
  logic         kc_init;
  logic [63:0]  kc_in;
  logic         kc_in_valid;
  logic         kc_is_last;
  logic [2:0]   kc_byte_num;
  logic         kc_buf_full;
  logic [511:0] kc_out;
  logic         kc_out_ready;
  logic         err;

  int          vectors = 0;
  int          miscompares = 0;
  bit          rand_bp = 1'b0;
  logic [67:0] lanes[$];      // {is_last, byte_num, lane} as seen by the core
  logic [67:0] exp_lanes[$];
  logic [31:0] digest[16];

  always #5 clk = ~clk;

  or1200_keccak_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cust5_valid  (cust5_valid),
    .cust5_op     (cust5_op),
    .cust5_limm   (cust5_limm),
    .cust5_a      (cust5_a),
    .stall        (stall),
    .result       (result),
    .result_valid (result_valid),
    .kc_init      (kc_init),
    .kc_in        (kc_in),
    .kc_in_valid  (kc_in_valid),
    .kc_is_last   (kc_is_last),
    .kc_byte_num  (kc_byte_num),
    .kc_buf_full  (kc_buf_full),
    .kc_out       (kc_out),
    .kc_out_ready (kc_out_ready),
    .err          (err)
  );

  // Core side: a lane is taken at the rising edge following a negedge with valid & !full.
  always @(negedge clk) begin
    if (!rst && kc_in_valid && !kc_buf_full) lanes.push_back({kc_is_last, kc_byte_num, kc_in});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) kc_buf_full = ($urandom_range(0, 2) == 0);
  endtask

  task automatic issue(input logic [4:0] op, input logic [5:0] limm, input logic [31:0] a,
                       output int stalls, output bit to);
    bit done;
    stalls = 0;
    to = 1'b0;
    cust5_valid = 1'b1;
    cust5_op = op;
    cust5_limm = limm;
    cust5_a = a;
    forever begin
      @(negedge clk);
      done = !stall;
      tick();
      if (done) break;
      stalls++;
      if (stalls > 200) begin
        to = 1'b1;
        break;
      end
    end
    cust5_valid = 1'b0;
  endtask

  task automatic wait_lanes(input int n, output bit to);
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (lanes.size() >= n) begin
        to = 1'b0;
        break;
      end
      tick();
    end
  endtask

  // Words pair up in issue order; an odd trailing word is padded with zero.
  function automatic void model_msg(input logic [31:0] w[$], input logic [2:0] bn);
    logic [31:0] lo;
    bit last;
    exp_lanes.delete();
    for (int i = 0; i < w.size(); i += 2) begin
      lo = (i + 1 < w.size()) ? w[i+1] : 32'h0;
      last = (i + 2 >= w.size());
      exp_lanes.push_back({last, last ? bn : 3'd0, w[i], lo});
    end
  endfunction

  task automatic send_msg(input logic [31:0] w[$], input logic [5:0] limm, output bit to);
    int s;
    bit t;
    to = 1'b0;
    model_msg(w, limm[2:0]);
    issue(OpStart, 6'd0, w[0], s, t);
    to |= t;
    for (int i = 1; i < w.size() - 1; i++) begin
      issue(OpMiddle, 6'd0, w[i], s, t);
      to |= t;
    end
    issue(OpEnd, limm, w[w.size()-1], s, t);
    to |= t;
  endtask

  task automatic load_digest();
    for (int i = 0; i < 16; i++) kc_out[32*i +: 32] = digest[i];
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({stall, result_valid, kc_init, kc_in_valid, kc_is_last, err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 000000",
               {stall, result_valid, kc_init, kc_in_valid, kc_is_last, err});
    end
    vectors++;
    if ({result, kc_in, kc_byte_num} !== 99'b0) begin
      miscompares++;
      $display("FAIL reset_data: got result=%h kc_in=%h byte_num=%0d want 0", result, kc_in,
               kc_byte_num);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_init();
    int s;
    bit t;
    issue(OpInit, 6'd0, 32'h0, s, t);
    vectors++;
    if (t || s != 0 || kc_init !== 1'b1) begin
      miscompares++;
      $display("FAIL init_pulse: got stalls=%0d kc_init=%b want 0 and 1", s, kc_init);
    end
    tick();
    vectors++;
    if (kc_init !== 1'b0) begin
      miscompares++;
      $display("FAIL init_pulse_end: got kc_init=%b want 0", kc_init);
    end
  endtask

  task automatic test_two_lane();
    int s;
    bit t, to;
    logic [31:0] w[$];
    logic [67:0] g0, g1;
    issue(OpInit, 6'd0, 32'h0, s, t);
    lanes.delete();
    w = '{32'd1, 32'd2, 32'd3, 32'd4};
    send_msg(w, 6'd1, to);
    wait_lanes(2, t);
    vectors++;
    if (to || t || lanes.size() != 2) begin
      miscompares++;
      $display("FAIL two_lane_count: got %0d lanes want 2", lanes.size());
    end else begin
      g0 = lanes[0];
      g1 = lanes[1];
      vectors++;
      if (g0[63:0] !== 64'h00000001_00000002 || g0[67] !== 1'b0) begin
        miscompares++;
        $display("FAIL two_lane_first: got %h last=%b want 0000000100000002 last=0", g0[63:0],
                 g0[67]);
      end
      vectors++;
      if (g1[63:0] !== 64'h00000003_00000004 || g1[67] !== 1'b1 || g1[66:64] !== 3'd1) begin
        miscompares++;
        $display("FAIL two_lane_last: got %h last=%b bn=%0d want 0000000300000004 last=1 bn=1",
                 g1[63:0], g1[67], g1[66:64]);
      end
    end
  endtask

  task automatic test_backpressure();
    int s;
    bit t;
    logic [67:0] g;
    issue(OpInit, 6'd0, 32'h0, s, t);
    lanes.delete();
    kc_buf_full = 1'b1;
    issue(OpStart, 6'd0, 32'd1, s, t);
    issue(OpMiddle, 6'd0, 32'd2, s, t);
    cust5_valid = 1'b1;
    cust5_op = OpMiddle;
    cust5_a = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (stall !== 1'b1 || kc_in_valid !== 1'b1 || kc_in !== 64'h00000001_00000002) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got stall=%b valid=%b kc_in=%h want 1 1 0000000100000002", i,
                 stall, kc_in_valid, kc_in);
      end
      tick();
    end
    kc_buf_full = 1'b0;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b1 || kc_in_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_accept_cycle: got stall=%b valid=%b want 1 1", stall, kc_in_valid);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0 || kc_in_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_after: got stall=%b valid=%b want 0 0", stall, kc_in_valid);
    end
    tick();
    cust5_valid = 1'b0;
    vectors++;
    g = (lanes.size() == 1) ? lanes[0] : 68'h0;
    if (lanes.size() != 1 || g[63:0] !== 64'h00000001_00000002) begin
      miscompares++;
      $display("FAIL bp_lane: got %0d lanes first=%h want 1 lane 0000000100000002",
               lanes.size(), g[63:0]);
    end
  endtask

  task automatic test_store();
    int s;
    bit t, to;
    logic [31:0] w[$];
    issue(OpInit, 6'd0, 32'h0, s, t);
    lanes.delete();
    w = '{32'h10, 32'h11};
    send_msg(w, 6'd0, to);
    wait_lanes(1, t);
    for (int i = 0; i < 16; i++) digest[i] = $urandom;
    digest[15] = 32'hDEADBEEF;
    load_digest();
    cust5_valid = 1'b1;
    cust5_op = OpStore;
    cust5_limm = 6'd15;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (stall !== 1'b1) begin
        miscompares++;
        $display("FAIL store_wait_stall%0d: got stall=%b want 1", i, stall);
      end
      tick();
    end
    kc_out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL store_ready_cycle: got stall=%b want 1", stall);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL store_done_stall: got stall=%b want 0", stall);
    end
    tick();
    vectors++;
    if (result_valid !== 1'b1 || result !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL store_w15: got valid=%b result=%h want 1 deadbeef", result_valid, result);
    end
    cust5_limm = 6'd3;
    @(negedge clk);
    tick();
    vectors++;
    if (result_valid !== 1'b1 || result !== digest[3]) begin
      miscompares++;
      $display("FAIL store_b2b: got valid=%b result=%h want 1 %h", result_valid, result,
               digest[3]);
    end
    cust5_valid = 1'b0;
    tick();
    vectors++;
    if (result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL store_pulse_end: got valid=%b want 0", result_valid);
    end
    kc_out_ready = 1'b0;
  endtask

  task automatic test_odd_end();
    int s;
    bit t, to;
    logic [31:0] w[$];
    logic [67:0] g0, g1;
    issue(OpInit, 6'd0, 32'h0, s, t);
    lanes.delete();
    w = '{32'd7, 32'd9};
    send_msg(w, 6'd4, to);
    wait_lanes(1, t);
    g0 = (lanes.size() == 1) ? lanes[0] : 68'h0;
    vectors++;
    if (to || lanes.size() != 1 || g0 !== {1'b1, 3'd4, 64'h00000007_00000009}) begin
      miscompares++;
      $display("FAIL odd_end_pair: got %0d lanes %h want 1 lane c00000007_00000009",
               lanes.size(), g0);
    end
    issue(OpInit, 6'd0, 32'h0, s, t);
    lanes.delete();
    w = '{32'd7, 32'd8, 32'd9};
    send_msg(w, 6'd4, to);
    wait_lanes(2, t);
    vectors++;
    if (to || lanes.size() != 2) begin
      miscompares++;
      $display("FAIL odd_end_count: got %0d lanes want 2", lanes.size());
    end else begin
      g0 = lanes[0];
      g1 = lanes[1];
      vectors++;
      if (g0[67] !== 1'b0 || g0[63:0] !== 64'h00000007_00000008 ||
          g1 !== {1'b1, 3'd4, 64'h00000009_00000000}) begin
        miscompares++;
        $display("FAIL odd_end_pad: got %h / %h want 0000000700000008 / c0000000900000000",
                 g0[63:0], g1);
      end
    end
  endtask

  task automatic test_err();
    int s;
    bit t;
    issue(OpInit, 6'd0, 32'h0, s, t);
    lanes.delete();
`ifdef KECCAK_CTRL_ERR_EN
    issue(OpMiddle, 6'd0, 32'd5, s, t);
    vectors++;
    if (t || s != 0 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_set: got stalls=%0d err=%b want 0 1", s, err);
    end
    repeat (3) tick();
    vectors++;
    if (lanes.size() != 0 || kc_in_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL err_no_lane: got %0d lanes valid=%b want 0 0", lanes.size(), kc_in_valid);
    end
    issue(OpInit, 6'd0, 32'h0, s, t);
    vectors++;
    if (err !== 1'b0 || kc_init !== 1'b1) begin
      miscompares++;
      $display("FAIL err_clear: got err=%b kc_init=%b want 0 1", err, kc_init);
    end
    tick();
    vectors++;
    if (kc_init !== 1'b0) begin
      miscompares++;
      $display("FAIL err_init_pulse: got kc_init=%b want 0", kc_init);
    end
`else
    issue(OpMiddle, 6'd0, 32'd5, s, t);
    issue(OpEnd, 6'd2, 32'd6, s, t);
    wait_lanes(1, t);
    vectors++;
    if (t || lanes.size() != 1 || lanes[0] !== {1'b1, 3'd2, 64'h00000005_00000006} ||
        err !== 1'b0) begin
      miscompares++;
      $display("FAIL implicit_start: got %0d lanes err=%b want lane a0000000500000006 err=0",
               lanes.size(), err);
    end
`endif
  endtask

  task automatic test_reset_mid_push();
    int s;
    bit t;
    issue(OpInit, 6'd0, 32'h0, s, t);
    lanes.delete();
    kc_buf_full = 1'b1;
    issue(OpStart, 6'd0, 32'd1, s, t);
    issue(OpMiddle, 6'd0, 32'd2, s, t);
    cust5_valid = 1'b1;
    cust5_op = OpMiddle;
    cust5_a = 32'd3;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b1 || kc_in_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre: got stall=%b valid=%b want 1 1", stall, kc_in_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({kc_in_valid, stall, result_valid, err} !== 4'b0) begin
      miscompares++;
      $display("FAIL rst_async: got valid/stall/rvalid/err=%b want 0000",
               {kc_in_valid, stall, result_valid, err});
    end
    cust5_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    kc_buf_full = 1'b0;
    repeat (3) tick();
    vectors++;
    if (lanes.size() != 0 || kc_in_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_lane_dropped: got %0d lanes valid=%b want 0 0", lanes.size(),
               kc_in_valid);
    end
    issue(OpStart, 6'd0, 32'd5, s, t);
    vectors++;
    if (t || s != 0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_idle: got start stalls=%0d err=%b want 0 0", s, err);
    end
  endtask

  task automatic test_random();
    int s, nw, nst, idx;
    bit t, to;
    logic [31:0] w[$];
    logic [5:0] limm;
    logic [67:0] g, e;
    issue(OpInit, 6'd0, 32'h0, s, t);
    rand_bp = 1'b1;
    for (int m = 0; m < 12; m++) begin
      nw = $urandom_range(2, 9);
      w.delete();
      for (int i = 0; i < nw; i++) w.push_back($urandom);
      limm = 6'($urandom_range(0, 63));
      lanes.delete();
      send_msg(w, limm, to);
      wait_lanes(exp_lanes.size(), t);
      vectors++;
      if (to || t || lanes.size() != exp_lanes.size()) begin
        miscompares++;
        $display("FAIL rand_count m%0d: got %0d lanes want %0d", m, lanes.size(),
                 exp_lanes.size());
      end
      for (int i = 0; i < exp_lanes.size() && i < lanes.size(); i++) begin
        g = lanes[i];
        e = exp_lanes[i];
        vectors++;
        if (g[63:0] !== e[63:0] || g[67] !== e[67] || (e[67] && g[66:64] !== e[66:64])) begin
          miscompares++;
          $display("FAIL rand_lane m%0d l%0d: got %h want %h", m, i, g, e);
        end
      end
      repeat ($urandom_range(0, 3)) tick();
      for (int i = 0; i < 16; i++) digest[i] = $urandom;
      load_digest();
      kc_out_ready = 1'b1;
      nst = $urandom_range(1, 3);
      for (int k = 0; k < nst; k++) begin
        idx = $urandom_range(0, 15);
        issue(OpStore, {2'($urandom_range(0, 3)), 4'(idx)}, $urandom, s, t);
        vectors++;
        if (t || result_valid !== 1'b1 || result !== digest[idx]) begin
          miscompares++;
          $display("FAIL rand_store m%0d w%0d: got valid=%b result=%h want 1 %h", m, idx,
                   result_valid, result, digest[idx]);
        end
      end
      tick();
      kc_out_ready = 1'b0;
    end
    rand_bp = 1'b0;
    kc_buf_full = 1'b0;
  endtask

  initial begin
    cust5_valid = 1'b0;
    cust5_op = OpInit;
    cust5_limm = 6'd0;
    cust5_a = 32'h0;
    kc_buf_full = 1'b0;
    kc_out = '0;
    kc_out_ready = 1'b0;
    test_reset();
    test_init();
    test_two_lane();
    test_backpressure();
    test_store();
    test_odd_end();
    test_err();
    test_reset_mid_push();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
